// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one 64-bit combinational ALU: accept -> execute -> respond.
// ALU_ARB_RR_EN selects round-robin contention; undefined gives fixed priority at RESET_PRIO.

module alu_arb_rsp_slot #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic             clr,
  input  logic [WIDTH-1:0] ans_in,
  input  logic             zero_in,
  output logic             valid,
  output logic [WIDTH-1:0] ans,
  output logic             zero
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ans   <= '0;
      zero  <= 1'b0;
    end else if (cap) begin
      valid <= 1'b1;
      ans   <= ans_in;
      zero  <= zero_in;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end
endmodule

module alu_share_arbiter #(
  parameter int WIDTH      = 64,
  parameter int OPT_W      = 4,
  parameter int RESET_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPT_W-1:0] req0_opt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPT_W-1:0] req1_opt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPT_W-1:0] alu_opt,
  input  logic [WIDTH-1:0] alu_ans,
  input  logic             alu_zero,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_ans,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_ans,
  output logic             rsp1_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   sel, gnt, prio, hs;
  logic [1:0]            cap, clr, rsp_rdy, rsp_vld, rsp_zero;
  logic [1:0][WIDTH-1:0] rsp_ans;
  logic [WIDTH-1:0]      sel_a, sel_b;
  logic [OPT_W-1:0]      sel_opt;

  // Undefined opcodes collapse to PASS-B so the ALU never sees them.
  function automatic logic [OPT_W-1:0] legal_opt(input logic [OPT_W-1:0] o);
    case (o)
      OPT_W'(4'b0000), OPT_W'(4'b0001), OPT_W'(4'b0010),
      OPT_W'(4'b0110), OPT_W'(4'b0111), OPT_W'(4'b1100): return o;
      default:                                           return OPT_W'(4'b0111);
    endcase
  endfunction

  assign rsp_rdy = {rsp1_ready, rsp0_ready};
  assign sel     = (req0_valid && req1_valid) ? prio : req1_valid;
  assign sel_a   = sel ? req1_a   : req0_a;
  assign sel_b   = sel ? req1_b   : req0_b;
  assign sel_opt = sel ? req1_opt : req0_opt;

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    hs         = 1'b0;
    cap        = '0;
    clr        = '0;
    case (state)
      IDLE: begin
        req0_ready = ~rst & req0_valid & ~sel;
        req1_ready = ~rst & req1_valid & sel;
        hs         = req0_ready | req1_ready;
        if (hs) state_nxt = EXEC;
      end
      EXEC: begin
        cap[gnt]  = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_rdy[gnt]) begin
          clr[gnt]  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_opt <= '0;
      gnt     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        alu_a   <= sel_a;
        alu_b   <= sel_b;
        alu_opt <= legal_opt(sel_opt);
        gnt     <= sel;
      end
    end
  end

`ifdef ALU_ARB_RR_EN
  // Favour the loser of each grant so sustained contention alternates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     prio <= 1'(RESET_PRIO);
    else if (hs) prio <= ~sel;
  end
`else
  assign prio = 1'(RESET_PRIO);
`endif

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    alu_arb_rsp_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .cap     (cap[i]),
      .clr     (clr[i]),
      .ans_in  (alu_ans),
      .zero_in (alu_zero),
      .valid   (rsp_vld[i]),
      .ans     (rsp_ans[i]),
      .zero    (rsp_zero[i])
    );
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp0_ans   = rsp_ans[0];
  assign rsp0_zero  = rsp_zero[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp1_ans   = rsp_ans[1];
  assign rsp1_zero  = rsp_zero[1];
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized + directed bench for alu_share_arbiter against a transaction-level reference model.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [63:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0]  req0_opt = 0, req1_opt = 0;
  logic [63:0] alu_a, alu_b, alu_ans;
  logic [3:0]  alu_opt;
  logic        alu_zero;
  logic        rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  logic [63:0] rsp0_ans, rsp1_ans;

  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_opt(req0_opt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_opt(req1_opt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opt(alu_opt), .alu_ans(alu_ans), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_ans(rsp0_ans), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_ans(rsp1_ans), .rsp1_zero(rsp1_zero)
  );

  function automatic logic [63:0] alu_f(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    case (o)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      default: return 64'h0;
    endcase
  endfunction

  // The shared ALU itself, modelled combinationally.
  always_comb begin
    alu_ans  = alu_f(alu_opt, alu_a, alu_b);
    alu_zero = (alu_ans == 64'h0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: at most one transaction in flight, described by its accept cycle.
  bit          pend = 0, pid = 0, prio = 0;
  int          tacc = 0, cyc = 0;
  logic [63:0] pa, pb, pans;
  logic [3:0]  popt;
  bit          pz;
  logic [63:0] last_ans [2] = '{64'h0, 64'h0};
  bit          last_z [2] = '{1'b0, 1'b0};

  task automatic step(input bit v0, input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] o0,
                      input bit v1, input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] o1,
                      input bit r0, input bit r1);
    bit erv0, erv1, ew, er0, er1, rr;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_opt = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_opt = o1;
    rsp0_ready = r0; rsp1_ready = r1;
    #1;
    erv0 = pend && !pid && (cyc >= tacc + 2);
    erv1 = pend &&  pid && (cyc >= tacc + 2);
    er0 = 0; er1 = 0;
    if (!pend) begin
      ew  = (v0 && v1) ? prio : v1;
      er0 = v0 && !ew;
      er1 = v1 && ew;
    end
    chk("req0_ready", req0_ready, er0);
    chk("req1_ready", req1_ready, er1);
    chk("rsp0_valid", rsp0_valid, erv0);
    chk("rsp1_valid", rsp1_valid, erv1);
    chk("rsp0_ans",   rsp0_ans,   last_ans[0]);
    chk("rsp0_zero",  rsp0_zero,  last_z[0]);
    chk("rsp1_ans",   rsp1_ans,   last_ans[1]);
    chk("rsp1_zero",  rsp1_zero,  last_z[1]);
    if (pend && cyc == tacc + 1) begin
      chk("alu_opt", alu_opt, popt);
      chk("alu_a",   alu_a,   pa);
      chk("alu_b",   alu_b,   pb);
    end
    // Advance the model across the coming rising edge.
    rr = pid ? r1 : r0;
    if (pend && cyc == tacc + 1) begin
      last_ans[pid] = pans;
      last_z[pid]   = pz;
    end
    if (pend && cyc >= tacc + 2 && rr) begin
      pend = 0;
    end else if (!pend && (er0 || er1)) begin
      pend = 1;
      pid  = er1;
      tacc = cyc;
      pa   = er1 ? a1 : a0;
      pb   = er1 ? b1 : b0;
      popt = er1 ? o1 : o0;
      if (!(popt inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100})) popt = 4'b0111;
      pans = alu_f(popt, pa, pb);
      pz   = (pans == 64'h0);
`ifdef ALU_ARB_RR_EN
      prio = !er1;
`endif
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  // Asynchronous reset pulse in the middle of a low clock phase.
  task automatic pulse_reset();
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    #1 rst = 1'b1;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_alu_a",      alu_a,      0);
    chk("rst_alu_b",      alu_b,      0);
    chk("rst_alu_opt",    alu_opt,    0);
    chk("rst_rsp0_ans",   rsp0_ans,   0);
    chk("rst_rsp1_ans",   rsp1_ans,   0);
    chk("rst_rsp0_zero",  rsp0_zero,  0);
    chk("rst_rsp1_zero",  rsp1_zero,  0);
    #1 rst = 1'b0;
    pend = 0; prio = 0;
    last_ans[0] = 0; last_ans[1] = 0; last_z[0] = 0; last_z[1] = 0;
    cyc++;
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [3:0]  ro;
    pulse_reset();

    // Single ADD on requester 0: 5 + 3.
    step(1, 64'd5, 64'd3, 4'b0010, 0, 0, 0, 0, 1, 1);
    idle(3);
    // Zero flag via SUB and via NOR of all-ones.
    step(0, 0, 0, 0, 1, 64'd7, 64'd7, 4'b0110, 1, 1);
    idle(3);
    step(0, 0, 0, 0, 1, '1, '1, 4'b1100, 1, 1);
    idle(3);
    // Illegal opcode falls back to PASS-B.
    step(1, 64'd1, 64'hDEAD, 4'b1111, 0, 0, 0, 0, 1, 1);
    idle(3);
    chk("illegal_ans", rsp0_ans, 64'hDEAD);

    // Sustained contention.
    for (int i = 0; i < 12; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      step(1, ra, rb, 4'b0010, 1, rb, ra, 4'b0001, 1, 1);
    end
    idle(3);

    // Response backpressure with requester 1 waiting.
    step(1, 64'h1234, 64'h0F0F, 4'b0000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 64'd9, 64'd4, 4'b0110, 0, 1);
    step(0, 0, 0, 0, 1, 64'd9, 64'd4, 4'b0110, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 64'd9, 64'd4, 4'b0110, 1, 1);
    idle(3);

    // Reset while in EXEC, then a normal transaction.
    step(1, 64'd11, 64'd22, 4'b0010, 0, 0, 0, 0, 1, 1);
    pulse_reset();
    idle(4);
    step(0, 0, 0, 0, 1, 64'd40, 64'd2, 4'b0110, 1, 1);
    idle(3);

    // Random traffic, including illegal opcodes and equal operands.
    for (int i = 0; i < 400; i++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
      ro = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), ra, rb, ro,
           1'($urandom_range(0, 1)), rb, ra, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
